// File: rtl/path_ctrl_pkg.sv
// Shared widths and helpers for the per-VC router input controller.
package path_ctrl_pkg;

   localparam int unsigned DEF_DATA_W  = 64;
   localparam int unsigned DEF_NUM_VC  = 2;
   localparam int unsigned DEF_DEPTH   = 4;
   localparam int unsigned DEF_HOP_LSB = 48;
   localparam int unsigned DEF_HOP_W   = 8;

   localparam int unsigned VC_W  = $clog2(DEF_NUM_VC);
   localparam int unsigned CNT_W = $clog2(DEF_DEPTH) + 1;

   // Widest packet the helpers accept; callers zero-extend and truncate back.
   localparam int unsigned MAX_DATA_W = 256;

   // Halve the hop field in place (logical shift right by one), other bits untouched.
   function automatic logic [MAX_DATA_W-1:0] hop_shift(input logic [MAX_DATA_W-1:0] pkt,
                                                       input int unsigned lsb,
                                                       input int unsigned w);
      logic [MAX_DATA_W-1:0] sh;
      logic [MAX_DATA_W-1:0] res;
      sh  = pkt >> 1;
      res = pkt;
      for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
         if ((i >= lsb) && (i < lsb + w)) begin
            res[i] = (i == lsb + w - 1) ? 1'b0 : sh[i];
         end
      end
      return res;
   endfunction

   // VC that may request the router while ph is accepting from the link.
   function automatic int unsigned next_vc(input int unsigned ph, input int unsigned num_vc);
      return (ph + 1) % num_vc;
   endfunction

endpackage

// File: rtl/vc_fifo.sv
// Circular-buffer FIFO for one virtual channel; storage is not reset.
module vc_fifo #(
   parameter  int unsigned DATA_W = 64,
   parameter  int unsigned DEPTH  = 4,
   localparam int unsigned PTR_W  = $clog2(DEPTH),
   localparam int unsigned CNT_W  = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] head,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;

   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   assign full  = (r_count == CNT_W'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;
   assign head  = r_mem[r_rd_ptr];

   // Data storage write; contents are don't-care until counted.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

   // Pointer and occupancy tracking; power-of-two depth wraps naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/path_input_ctrl_vc.sv
// Router input channel controller: per-VC FIFOs, phase-selected push/request, error tracking.
module path_input_ctrl_vc
   import path_ctrl_pkg::*;
#(
   parameter  int unsigned DATA_W   = DEF_DATA_W,
   parameter  int unsigned NUM_VC   = DEF_NUM_VC,
   parameter  int unsigned DEPTH    = DEF_DEPTH,
   parameter  int unsigned HOP_LSB  = DEF_HOP_LSB,
   parameter  int unsigned HOP_W    = DEF_HOP_W,
   localparam int unsigned VC_BITS  = $clog2(NUM_VC),
   localparam int unsigned CNT_BITS = $clog2(DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [VC_BITS-1:0]         phase,
   input  logic [DATA_W-1:0]          ch2in_din,
   input  logic                       ch2in_vld,
   output logic                       in2ch_rdy,
   output logic                       in2path_req,
   output logic                       in2pe_req,
   input  logic                       path2in_gnt,
   input  logic                       pe2in_gnt,
   output logic [DATA_W-1:0]          in2out_dout,
   output logic [NUM_VC*CNT_BITS-1:0] vc_occ,
   output logic                       err_flag,
   output logic [7:0]                 err_cnt
);

   logic [VC_BITS-1:0]  w_wvc;
   logic [VC_BITS-1:0]  w_rvc;
   logic [VC_BITS-1:0]  w_vc_field;
   logic                w_xfer;
   logic                w_push;
   logic                w_drop;
   logic                w_gnt;
   logic [DATA_W-1:0]   w_push_data;
   logic [DATA_W-1:0]   w_rhead;
   logic [HOP_W-1:0]    w_hop;
   logic [NUM_VC-1:0]   w_full;
   logic [NUM_VC-1:0]   w_empty;
   logic [NUM_VC-1:0]   w_push_vc;
   logic [NUM_VC-1:0]   w_pop_vc;
   logic [DATA_W-1:0]   w_head  [NUM_VC];
   logic [CNT_BITS-1:0] w_count [NUM_VC];
   logic                r_err_flag;
   logic [7:0]          r_err_cnt;

   // Phase decode: write and read VCs are always distinct.
   assign w_wvc      = phase;
   assign w_rvc      = VC_BITS'(next_vc(32'(phase), NUM_VC));
   assign w_vc_field = ch2in_din[DATA_W-1 -: VC_BITS];

   // Link side: ready depends only on the write VC's fullness.
   assign in2ch_rdy   = ~w_full[w_wvc];
   assign w_xfer      = ch2in_vld & in2ch_rdy;
   assign w_push      = w_xfer & (w_vc_field == w_wvc);
   assign w_drop      = w_xfer & (w_vc_field != w_wvc);
   assign w_push_data = DATA_W'(hop_shift(MAX_DATA_W'(ch2in_din), HOP_LSB, HOP_W));

   // Router side: the read VC head requests path or PE by its hop count.
   assign w_rhead     = w_head[w_rvc];
   assign w_hop       = w_rhead[HOP_LSB +: HOP_W];
   assign in2path_req = ~w_empty[w_rvc] & (w_hop != '0);
   assign in2pe_req   = ~w_empty[w_rvc] & (w_hop == '0);

   // Requests are exclusive, so a path grant never masks a PE grant that matches.
   assign w_gnt       = (path2in_gnt & in2path_req) | (pe2in_gnt & in2pe_req);
   assign in2out_dout = w_gnt ? w_rhead : '0;

   for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
      assign w_push_vc[g] = w_push & (w_wvc == VC_BITS'(g));
      assign w_pop_vc[g]  = w_gnt & (w_rvc == VC_BITS'(g));

      vc_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (w_push_vc[g]),
         .pop   (w_pop_vc[g]),
         .din   (w_push_data),
         .head  (w_head[g]),
         .count (w_count[g]),
         .full  (w_full[g]),
         .empty (w_empty[g])
      );

      assign vc_occ[g*CNT_BITS +: CNT_BITS] = w_count[g];
   end

   // Sticky mismatch flag and saturating mismatch counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_flag <= 1'b0;
         r_err_cnt  <= '0;
      end else if (w_drop) begin
         r_err_flag <= 1'b1;
         if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign err_flag = r_err_flag;
   assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_path_input_ctrl_vc.sv
// Self-checking bench for path_input_ctrl_vc (2-VC default build plus a 4-VC build).
module tb_path_input_ctrl_vc;
   import path_ctrl_pkg::*;

   localparam int unsigned DW  = DEF_DATA_W;
   localparam int unsigned CW  = CNT_W;
   localparam int unsigned DEP = DEF_DEPTH;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic [VC_W-1:0] phase;
   logic [DW-1:0]   din;
   logic            vld, pg, eg;
   logic            rdy, preq, ereq;
   logic [DW-1:0]   dout;
   logic [2*CW-1:0] occ;
   logic            eflag;
   logic [7:0]      ecnt;

   logic [1:0]      phase4;
   logic [DW-1:0]   din4;
   logic            vld4, pg4, eg4;
   logic            rdy4, preq4, ereq4;
   logic [DW-1:0]   dout4;
   logic [4*CW-1:0] occ4;
   logic            eflag4;
   logic [7:0]      ecnt4;

   always #5 clk = ~clk;

   path_input_ctrl_vc u_dut (
      .clk(clk), .rst(rst), .phase(phase), .ch2in_din(din), .ch2in_vld(vld),
      .in2ch_rdy(rdy), .in2path_req(preq), .in2pe_req(ereq),
      .path2in_gnt(pg), .pe2in_gnt(eg), .in2out_dout(dout),
      .vc_occ(occ), .err_flag(eflag), .err_cnt(ecnt)
   );

   path_input_ctrl_vc #(.NUM_VC(4)) u_dut4 (
      .clk(clk), .rst(rst), .phase(phase4), .ch2in_din(din4), .ch2in_vld(vld4),
      .in2ch_rdy(rdy4), .in2path_req(preq4), .in2pe_req(ereq4),
      .path2in_gnt(pg4), .pe2in_gnt(eg4), .in2out_dout(dout4),
      .vc_occ(occ4), .err_flag(eflag4), .err_cnt(ecnt4)
   );

   int nchk = 0;
   int nerr = 0;

   // Reference model: one queue of stored packets per VC plus a mismatch tally.
   logic [63:0] mq [2][$];
   int          merr;
   bit          m_gnt, m_rdy;
   int          m_w;

   function automatic logic [63:0] mk(input logic vc, input logic [7:0] hop, input logic [47:0] pl);
      return {vc, 7'b0, hop, pl};
   endfunction

   function automatic logic [63:0] mk4(input logic [1:0] vc, input logic [7:0] hop, input logic [47:0] pl);
      return {vc, 6'b0, hop, pl};
   endfunction

   function automatic logic [63:0] shp(input logic [63:0] p);
      logic [63:0] r;
      r = p;
      r[55:48] = p[55:48] / 8'd2;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare every output of the 2-VC DUT against the model for the current inputs.
   task automatic model_check();
      int          r;
      bit          ne;
      logic [63:0] head;
      bit          e_preq, e_ereq;
      m_w   = int'(phase);
      r     = (m_w + 1) % 2;
      m_rdy = (mq[m_w].size() < DEP);
      ne    = (mq[r].size() != 0);
      head  = '0;
      if (ne) head = mq[r][0];
      e_preq = ne && (head[55:48] != 8'd0);
      e_ereq = ne && (head[55:48] == 8'd0);
      m_gnt  = (pg && e_preq) || (eg && e_ereq);
      chk("rdy",   64'(rdy),  64'(m_rdy));
      chk("preq",  64'(preq), 64'(e_preq));
      chk("ereq",  64'(ereq), 64'(e_ereq));
      chk("dout",  dout, m_gnt ? head : 64'd0);
      chk("occ0",  64'(occ[CW-1:0]),    64'(mq[0].size()));
      chk("occ1",  64'(occ[2*CW-1:CW]), 64'(mq[1].size()));
      chk("eflag", 64'(eflag), 64'(merr > 0));
      chk("ecnt",  64'(ecnt),  64'((merr > 255) ? 255 : merr));
   endtask

   task automatic drive(input logic p, input logic v, input logic [63:0] d, input logic g1, input logic g2);
      phase = p; vld = v; din = d; pg = g1; eg = g2;
      #2;
      model_check();
   endtask

   task automatic tick();
      @(posedge clk);
      if (m_gnt) void'(mq[(m_w + 1) % 2].pop_front());
      if (vld && m_rdy) begin
         if (int'(din[63]) == m_w) mq[m_w].push_back(shp(din));
         else merr++;
      end
      @(negedge clk);
   endtask

   task automatic step(input logic p, input logic v, input logic [63:0] d, input logic g1, input logic g2);
      drive(p, v, d, g1, g2);
      tick();
   endtask

   task automatic do_reset();
      phase = '0; vld = 1'b0; din = '0; pg = 1'b0; eg = 1'b0;
      rst = 1'b0;
      mq[0].delete(); mq[1].delete(); merr = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   typedef struct {
      logic        ph;
      logic        v;
      logic [63:0] d;
      logic        g1, g2;
      logic        x_rdy, x_preq, x_ereq;
      logic [63:0] x_dout;
      int          x_occ0, x_occ1;
   } vec_t;

   vec_t tbl [7];

   initial begin
      logic [63:0] pa, pb, pkt;
      logic [63:0] expq [$];

      phase = '0; din = '0; vld = 1'b0; pg = 1'b0; eg = 1'b0;
      phase4 = '0; din4 = '0; vld4 = 1'b0; pg4 = 1'b0; eg4 = 1'b0;
      mq[0].delete(); mq[1].delete(); merr = 0;

      pa = 64'h0004_0000_0000_1111;
      pb = 64'h8001_0000_0000_2222;
      tbl[0] = '{1'b0, 1'b1, pa,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 0, 0};
      tbl[1] = '{1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0002_0000_0000_1111, 1, 0};
      tbl[2] = '{1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 0, 0};
      tbl[3] = '{1'b1, 1'b1, pb,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 0, 0};
      tbl[4] = '{1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_2222, 0, 1};
      tbl[5] = '{1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 0, 0};
      tbl[6] = '{1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 0, 0};

      // Reset state
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #2;
      chk("rst_rdy",  64'(rdy),  64'd1);
      chk("rst_preq", 64'(preq), 64'd0);
      chk("rst_ereq", 64'(ereq), 64'd0);
      chk("rst_dout", dout, 64'd0);
      chk("rst_occ",  64'(occ),  64'd0);
      chk("rst_eflag", 64'(eflag), 64'd0);
      chk("rst_ecnt", 64'(ecnt), 64'd0);
      chk("rst_occ4", 64'(occ4), 64'd0);
      @(negedge clk);

      // Table-driven directed vectors
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].ph, tbl[i].v, tbl[i].d, tbl[i].g1, tbl[i].g2);
         chk($sformatf("tbl%0d_rdy", i),  64'(rdy),  64'(tbl[i].x_rdy));
         chk($sformatf("tbl%0d_preq", i), 64'(preq), 64'(tbl[i].x_preq));
         chk($sformatf("tbl%0d_ereq", i), 64'(ereq), 64'(tbl[i].x_ereq));
         chk($sformatf("tbl%0d_dout", i), dout, tbl[i].x_dout);
         chk($sformatf("tbl%0d_occ0", i), 64'(occ[CW-1:0]),    64'(tbl[i].x_occ0));
         chk($sformatf("tbl%0d_occ1", i), 64'(occ[2*CW-1:CW]), 64'(tbl[i].x_occ1));
         tick();
      end

      // Fill VC0, extra valid is refused, phase change re-raises ready
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, mk(1'b0, 8'(i + 2), 48'(i)), 1'b0, 1'b0);
      drive(1'b0, 1'b1, mk(1'b0, 8'h09, 48'hBEEF), 1'b0, 1'b0);
      chk("full_rdy", 64'(rdy), 64'd0);
      tick();
      drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
      chk("full_occ0", 64'(occ[CW-1:0]), 64'd4);
      drive(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
      chk("full_phase_rdy", 64'(rdy), 64'd1);
      tick();

      // VC mismatch drop and saturation
      do_reset();
      step(1'b0, 1'b1, mk(1'b1, 8'h03, 48'h1234), 1'b0, 1'b0);
      drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
      chk("err_flag", 64'(eflag), 64'd1);
      chk("err_cnt1", 64'(ecnt),  64'd1);
      chk("err_occ",  64'(occ),   64'd0);
      tick();
      for (int i = 0; i < 299; i++) step(1'b0, 1'b1, mk(1'b1, 8'(i), 48'(i)), 1'b0, 1'b0);
      drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
      chk("err_sat", 64'(ecnt), 64'd255);
      tick();

      // Wrap-around through VC1: order and shifted hops preserved
      do_reset();
      for (int i = 0; i < 10; i++) begin
         pkt = mk(1'b1, 8'(i), {16'hA5A5, 32'(i)});
         step(1'b1, 1'b1, pkt, 1'b0, 1'b0);
         expq.push_back(shp(pkt));
         if (i >= 2) begin
            drive(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
            chk($sformatf("wrap_dout%0d", i), dout, expq.pop_front());
            tick();
         end
      end
      while (expq.size() != 0) begin
         drive(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
         chk("wrap_drain", dout, expq.pop_front());
         tick();
      end

      // Asynchronous reset with 3 entries buffered
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mk(1'b0, 8'h06, 48'(i)), 1'b0, 1'b0);
      drive(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
      chk("pre_rst_preq", 64'(preq), 64'd1);
      #1 rst = 1'b0;
      #1;
      chk("async_occ",  64'(occ),  64'd0);
      chk("async_preq", 64'(preq), 64'd0);
      chk("async_ereq", 64'(ereq), 64'd0);
      mq[0].delete(); mq[1].delete(); merr = 0;
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
      chk("post_rst_rdy", 64'(rdy), 64'd1);
      tick();

      // 4-VC build: phase 2 pushes to VC2 and requests from VC3
      do_reset();
      phase4 = 2'd2; vld4 = 1'b1; din4 = mk4(2'd2, 8'h04, 48'h2222); pg4 = 1'b1; eg4 = 1'b1;
      #2;
      chk("v4_rdy",   64'(rdy4),  64'd1);
      chk("v4_req0",  64'(preq4 | ereq4), 64'd0);
      @(posedge clk); @(negedge clk);
      phase4 = 2'd3; din4 = mk4(2'd3, 8'h06, 48'h3333); pg4 = 1'b0; eg4 = 1'b0;
      #2;
      chk("v4_occ2",  64'(occ4[2*CW +: CW]), 64'd1);
      chk("v4_occ0",  64'(occ4[0 +: CW]),    64'd0);
      @(posedge clk); @(negedge clk);
      phase4 = 2'd2; vld4 = 1'b0; din4 = '0; pg4 = 1'b1;
      #2;
      chk("v4_preq",  64'(preq4), 64'd1);
      chk("v4_dout",  dout4, shp(mk4(2'd3, 8'h06, 48'h3333)));
      chk("v4_occ3",  64'(occ4[3*CW +: CW]), 64'd1);
      @(posedge clk); @(negedge clk);
      pg4 = 1'b0;
      #2;
      chk("v4_occ3_pop", 64'(occ4[3*CW +: CW]), 64'd0);
      chk("v4_occ2_keep", 64'(occ4[2*CW +: CW]), 64'd1);
      chk("v4_occ1",  64'(occ4[1*CW +: CW]), 64'd0);
      chk("v4_noreq", 64'(preq4 | ereq4), 64'd0);
      @(negedge clk);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic p;
         logic vc;
         p  = 1'($urandom_range(1, 0));
         vc = ($urandom_range(3, 0) == 0) ? ~p : p;
         step(p, ($urandom_range(9, 0) < 7),
              mk(vc, 8'($urandom_range(3, 0)), {16'($urandom), 32'($urandom)}),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
